// File: rtl/stack_unit.sv
// Parametrised downward-growing hardware stack with its own circular storage.
// It drives the shared data bus and reports full/empty state and sticky overflow/underflow flags.
module stack_unit #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] TOP_ADDR = 8'hFF,
  parameter bit                WRAP     = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       oe,
  input  logic [DATA_W-1:0]          in,
  output logic [DATA_W-1:0]          out,
  output logic [DATA_W-1:0]          sp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] bot_q, bot_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [SW-1:0]     wr_sum;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     bot_inc;
  logic              is_full;
  logic              is_empty;
  logic [DATA_W-1:0] top_data;

  // Index arithmetic wraps by compare-and-subtract, so DEPTH need not be a power of two.
  assign wr_sum  = SW'(bot_q) + SW'(count_q);
  assign wr_idx  = (wr_sum >= SW'(DEPTH)) ? AW'(wr_sum - SW'(DEPTH)) : AW'(wr_sum);
  assign top_idx = (wr_idx == '0) ? AW'(DEPTH - 1) : wr_idx - AW'(1);
  assign bot_inc = (bot_q == AW'(DEPTH - 1)) ? '0 : bot_q + AW'(1);

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    // NOTE: every signal gets a default before the decision chain; a missed branch would otherwise infer a latch.
    count_d     = count_q;
    bot_d       = bot_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_idx;

    if (clear) begin
      count_d     = '0;
      bot_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop && !is_empty) begin
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (push && !is_full) begin
      // An empty stack is never full, so push+pop on empty lands here as a plain push.
      mem_we    = 1'b1;
      mem_waddr = wr_idx;
      count_d   = count_q + CW'(1);
    end else if (push) begin
      if (WRAP) begin
        // Overwrite the oldest slot; it becomes the new top once bot advances past it.
        mem_we    = 1'b1;
        mem_waddr = bot_q;
        bot_d     = bot_inc;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop && !is_empty) begin
      count_d = count_q - CW'(1);
    end else if (pop) begin
      underflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      bot_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      bot_q       <= bot_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= in;
    end
  end

  assign top_data = is_empty ? '0 : mem[top_idx];

  assign out       = oe ? top_data : 'z;
  assign sp        = TOP_ADDR - DATA_W'(count_q);
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a DEPTH=16 drop-on-full unit and a DEPTH=5 wrapping unit
// share one stimulus stream; each step checks the unit it targets against hand-computed values.
module tb_stack_unit;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       push;
  logic       pop;
  logic       oe;
  logic [7:0] din;

  logic [7:0] a_out, a_sp;
  logic [4:0] a_count;
  logic       a_full, a_empty, a_ovf, a_unf;

  logic [7:0] b_out, b_sp;
  logic [2:0] b_count;
  logic       b_full, b_empty, b_ovf, b_unf;

  int checks = 0;
  int errors = 0;

  stack_unit #(.DATA_W(8), .DEPTH(16), .TOP_ADDR(8'hFF), .WRAP(1'b0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .oe(oe),
    .in(din), .out(a_out), .sp(a_sp), .count(a_count), .full(a_full),
    .empty(a_empty), .overflow(a_ovf), .underflow(a_unf)
  );

  stack_unit #(.DATA_W(8), .DEPTH(5), .TOP_ADDR(8'hFF), .WRAP(1'b1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop), .oe(oe),
    .in(din), .out(b_out), .sp(b_sp), .count(b_count), .full(b_full),
    .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    oe    = 1'b1;
    din   = 8'h00;

    // Reset state, before any clock edge.
    #2;
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_sp",    32'(a_sp),    32'hFF);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_full",  32'(a_full),  32'd0);
    check("rst_out",   32'(a_out),   32'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Push three, read back LIFO order.
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check("p3_out",   32'(a_out),   32'h33);
    check("p3_sp",    32'(a_sp),    32'hFC);
    check("p3_count", 32'(a_count), 32'd3);
    step(1'b0, 1'b1, 8'h00);
    check("pop1_out", 32'(a_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    check("pop2_out", 32'(a_out), 32'h11);
    step(1'b0, 1'b1, 8'h00);
    check("pop3_out",   32'(a_out),   32'h00);
    check("pop3_empty", 32'(a_empty), 32'd1);
    check("pop3_unf",   32'(a_unf),   32'd0);

    // Underflow is sticky across pushes; then async reset mid-operation.
    step(1'b0, 1'b1, 8'h00);
    check("unf_set", 32'(a_unf), 32'd1);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
    check("unf_keep",  32'(a_unf),   32'd1);
    check("c5_count",  32'(a_count), 32'd5);
    check("c5_sp",     32'(a_sp),    32'hFA);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(a_count), 32'd0);
    check("arst_sp",    32'(a_sp),    32'hFF);
    check("arst_empty", 32'(a_empty), 32'd1);
    check("arst_unf",   32'(a_unf),   32'd0);
    check("arst_ovf",   32'(a_ovf),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // DEPTH=16 drop-on-full: 17 pushes, overflow, then drain.
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 8'(i));
    check("a_full",  32'(a_full),  32'd1);
    check("a_ovf",   32'(a_ovf),   32'd1);
    check("a_count", 32'(a_count), 32'd16);
    check("a_sp",    32'(a_sp),    32'hEF);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a_drain%0d", i), 32'(a_out), 32'(16 - i));
      step(1'b0, 1'b1, 8'h00);
    end
    check("a_drain_empty", 32'(a_empty), 32'd1);
    check("a_ovf_keep",    32'(a_ovf),   32'd1);

    // DEPTH=5 wrap mode: 7 pushes keep the newest five.
    clear = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    check("clr_b_count", 32'(b_count), 32'd0);
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 8'(i));
    check("b_count", 32'(b_count), 32'd5);
    check("b_ovf",   32'(b_ovf),   32'd0);
    check("b_full",  32'(b_full),  32'd1);
    check("b_sp",    32'(b_sp),    32'hFA);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b_drain%0d", i), 32'(b_out), 32'(7 - i));
      step(1'b0, 1'b1, 8'h00);
    end
    check("b_drain_empty", 32'(b_empty), 32'd1);

    // Replace-top, and push+pop on empty.
    clear = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'hAA);
    check("rep_pre", 32'(a_out), 32'hAA);
    step(1'b1, 1'b1, 8'h5C);
    check("rep_count", 32'(a_count), 32'd2);
    check("rep_top",   32'(a_out),   32'h5C);
    step(1'b0, 1'b1, 8'h00);
    check("rep_below", 32'(a_out), 32'h10);
    step(1'b0, 1'b1, 8'h00);
    check("rep_empty", 32'(a_empty), 32'd1);
    step(1'b1, 1'b1, 8'h01);
    check("pp_empty_count", 32'(a_count), 32'd1);
    check("pp_empty_unf",   32'(a_unf),   32'd0);
    check("pp_empty_out",   32'(a_out),   32'h01);

    // Sticky underflow, then clear beats a simultaneous push.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("unf2_set", 32'(a_unf), 32'd1);
    step(1'b1, 1'b0, 8'h42);
    check("unf2_keep", 32'(a_unf), 32'd1);
    check("unf2_top",  32'(a_out), 32'h42);
    clear = 1'b1;
    step(1'b1, 1'b0, 8'h99);
    check("clr_count", 32'(a_count), 32'd0);
    check("clr_unf",   32'(a_unf),   32'd0);
    check("clr_ovf",   32'(a_ovf),   32'd0);
    check("clr_empty", 32'(a_empty), 32'd1);
    check("clr_out",   32'(a_out),   32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
